uart_word_rx: RTL and testbench

- Parametrised successor to the fixed 32-bit UART word receiver.
- Contains its own 8N1 bit-level receiver and assembles BYTES_PER_WORD consecutive bytes into one word.
- Configurable byte order, inter-byte timeout and error flags.
- Hands finished words out over a valid/ready interface with a one-word holding register.
- Sits between the board RX pin and the loader/debug logic that writes instruction memory.

---
 rtl/uart_word_rx.sv | 161 ++++++++++++++++
 tb/tb_uart_word_rx.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_rx.sv
// 8N1 UART receiver that packs BYTES_PER_WORD bytes into a word and hands it
// out through a one-entry valid/ready holding register.
module uart_word_rx #(
  parameter int unsigned CLKS_PER_BIT   = 16,
  parameter int unsigned BYTES_PER_WORD = 4,
  parameter int unsigned LSB_FIRST      = 1,
  parameter int unsigned TIMEOUT_CLKS   = 0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          rx,
  output logic [8*BYTES_PER_WORD-1:0]   word_data,
  output logic                          word_valid,
  input  logic                          word_ready,
  output logic                          busy,
  output logic                          frame_err,
  output logic                          timeout_err,
  output logic                          overrun
);

  localparam int unsigned WORD_W = 8 * BYTES_PER_WORD;
  localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF   = CLKS_PER_BIT / 2;
  localparam int unsigned IDX_W  = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int unsigned TO_W   = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam int unsigned TO_LIM = (TIMEOUT_CLKS == 0) ? 0 : TIMEOUT_CLKS - 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic              r_rx_meta;
  logic              r_rx_sync;
  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic [CNT_W-1:0]  r_clk_cnt;
  logic [CNT_W-1:0]  w_clk_cnt_next;
  logic [2:0]        r_bit_idx;
  logic [2:0]        w_bit_idx_next;
  logic [7:0]        r_rx_byte;
  logic              w_data_sample;
  logic              w_stop_ok;
  logic              w_stop_bad;
  logic [IDX_W-1:0]  r_byte_idx;
  logic [IDX_W-1:0]  w_byte_idx_next;
  logic [IDX_W-1:0]  w_byte_pos;
  logic              w_word_done;
  logic [WORD_W-1:0] r_shift;
  logic [WORD_W-1:0] w_shift_next;
  logic [TO_W-1:0]   r_to_cnt;
  logic              w_to_count;
  logic              w_to_fire;

  // Bit-level FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // Bit-level next state and sample strobes
  always_comb begin
    w_state_next   = r_state;
    w_clk_cnt_next = r_clk_cnt + CNT_W'(1);
    w_bit_idx_next = r_bit_idx;
    w_data_sample  = 1'b0;
    w_stop_ok      = 1'b0;
    w_stop_bad     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_clk_cnt_next = '0;
        w_bit_idx_next = '0;
        if (!r_rx_sync) w_state_next = S_START;
      end
      S_START: begin
        if (r_clk_cnt == CNT_W'(HALF - 1)) begin
          w_clk_cnt_next = '0;
          w_state_next   = r_rx_sync ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          w_clk_cnt_next = '0;
          w_data_sample  = 1'b1;
          w_bit_idx_next = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          w_clk_cnt_next = '0;
          w_state_next   = S_IDLE;
          w_stop_ok      = r_rx_sync;
          w_stop_bad     = ~r_rx_sync;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Byte placement, word completion and inter-byte timeout decode
  always_comb begin
    w_word_done = w_stop_ok && (r_byte_idx == IDX_W'(BYTES_PER_WORD - 1));
    w_byte_pos  = (LSB_FIRST != 0) ? r_byte_idx : IDX_W'(BYTES_PER_WORD - 1) - r_byte_idx;
    w_shift_next = r_shift;
    w_shift_next[{w_byte_pos, 3'b000} +: 8] = r_rx_byte;
    // A start bit leaving IDLE freezes the timeout counter.
    w_to_count = (TIMEOUT_CLKS != 0) && (r_byte_idx != '0) &&
                 (r_state == S_IDLE) && (w_state_next == S_IDLE);
    w_to_fire  = w_to_count && (r_to_cnt == TO_W'(TO_LIM));
    w_byte_idx_next = r_byte_idx;
    if (w_stop_ok)                    w_byte_idx_next = w_word_done ? '0 : r_byte_idx + IDX_W'(1);
    else if (w_stop_bad || w_to_fire) w_byte_idx_next = '0;
  end

  // Datapath, flags and holding register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_meta   <= 1'b1;
      r_rx_sync   <= 1'b1;
      r_clk_cnt   <= '0;
      r_bit_idx   <= '0;
      r_rx_byte   <= '0;
      r_byte_idx  <= '0;
      r_shift     <= '0;
      r_to_cnt    <= '0;
      word_data   <= '0;
      word_valid  <= 1'b0;
      busy        <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      r_rx_meta   <= rx;
      r_rx_sync   <= r_rx_meta;
      r_clk_cnt   <= w_clk_cnt_next;
      r_bit_idx   <= w_bit_idx_next;
      r_byte_idx  <= w_byte_idx_next;
      frame_err   <= w_stop_bad;
      timeout_err <= w_to_fire;
      overrun     <= 1'b0;
      busy        <= (w_state_next != S_IDLE) || (w_byte_idx_next != '0);
      if (w_data_sample) r_rx_byte <= {r_rx_sync, r_rx_byte[7:1]};
      if (w_stop_ok)     r_shift   <= w_shift_next;
      if (w_stop_ok || w_stop_bad || w_to_fire) r_to_cnt <= '0;
      else if (w_to_count)                      r_to_cnt <= r_to_cnt + TO_W'(1);
      // A handshake in the same cycle frees the slot for the new word.
      if (w_word_done) begin
        if (!word_valid || word_ready) begin
          word_data  <= w_shift_next;
          word_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_word_rx.sv
// Scoreboard bench for uart_word_rx: four instances cover the default, MSB-first,
// two-byte and timeout configurations.
module tb_uart_word_rx;

  localparam int CPB = 16;

  logic        clk;
  logic        reset_n;
  logic [3:0]  rx_v;
  logic [3:0]  rdy;

  logic [31:0] wd0, wd1, wd3;
  logic [15:0] wd2;
  logic [3:0]  wv, bsy, fe, toe, ov;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc = 0;
  int rise_cyc0 = -1;
  int fe_cnt0 = 0, ov_cnt0 = 0, to_cnt3 = 0;
  logic wv0_prev = 1'b0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [15:0] q2[$];
  logic [31:0] q3[$];

  uart_word_rx #(.CLKS_PER_BIT(CPB)) u_def (
    .clk(clk), .reset_n(reset_n), .rx(rx_v[0]), .word_data(wd0), .word_valid(wv[0]),
    .word_ready(rdy[0]), .busy(bsy[0]), .frame_err(fe[0]), .timeout_err(toe[0]), .overrun(ov[0]));

  uart_word_rx #(.CLKS_PER_BIT(CPB), .LSB_FIRST(0)) u_msb (
    .clk(clk), .reset_n(reset_n), .rx(rx_v[1]), .word_data(wd1), .word_valid(wv[1]),
    .word_ready(rdy[1]), .busy(bsy[1]), .frame_err(fe[1]), .timeout_err(toe[1]), .overrun(ov[1]));

  uart_word_rx #(.CLKS_PER_BIT(CPB), .BYTES_PER_WORD(2)) u_b2 (
    .clk(clk), .reset_n(reset_n), .rx(rx_v[2]), .word_data(wd2), .word_valid(wv[2]),
    .word_ready(rdy[2]), .busy(bsy[2]), .frame_err(fe[2]), .timeout_err(toe[2]), .overrun(ov[2]));

  uart_word_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(400)) u_to (
    .clk(clk), .reset_n(reset_n), .rx(rx_v[3]), .word_data(wd3), .word_valid(wv[3]),
    .word_ready(rdy[3]), .busy(bsy[3]), .frame_err(fe[3]), .timeout_err(toe[3]), .overrun(ov[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Flag pulse counters and word-valid rise time
  always @(negedge clk) begin
    if (fe[0])  fe_cnt0 <= fe_cnt0 + 1;
    if (ov[0])  ov_cnt0 <= ov_cnt0 + 1;
    if (toe[3]) to_cnt3 <= to_cnt3 + 1;
    if (wv[0] && !wv0_prev) rise_cyc0 <= cyc;
    wv0_prev <= wv[0];
  end

  // Scoreboard: every accepted word is popped and compared
  always @(negedge clk) begin
    if (reset_n && wv[0] && rdy[0]) begin
      n_checks++;
      if (q0.size() == 0) begin
        n_fail++; $display("FAIL def_word: got %h, required no word", wd0);
      end else begin
        logic [31:0] e; e = q0.pop_front();
        if (wd0 !== e) begin n_fail++; $display("FAIL def_word: got %h, required %h", wd0, e); end
      end
    end
    if (reset_n && wv[1] && rdy[1]) begin
      n_checks++;
      if (q1.size() == 0) begin
        n_fail++; $display("FAIL msb_word: got %h, required no word", wd1);
      end else begin
        logic [31:0] e; e = q1.pop_front();
        if (wd1 !== e) begin n_fail++; $display("FAIL msb_word: got %h, required %h", wd1, e); end
      end
    end
    if (reset_n && wv[2] && rdy[2]) begin
      n_checks++;
      if (q2.size() == 0) begin
        n_fail++; $display("FAIL b2_word: got %h, required no word", wd2);
      end else begin
        logic [15:0] e; e = q2.pop_front();
        if (wd2 !== e) begin n_fail++; $display("FAIL b2_word: got %h, required %h", wd2, e); end
      end
    end
    if (reset_n && wv[3] && rdy[3]) begin
      n_checks++;
      if (q3.size() == 0) begin
        n_fail++; $display("FAIL to_word: got %h, required no word", wd3);
      end else begin
        logic [31:0] e; e = q3.pop_front();
        if (wd3 !== e) begin n_fail++; $display("FAIL to_word: got %h, required %h", wd3, e); end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input int sel, input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    @(posedge clk); #1;
    start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      rx_v[sel] = fr[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx_v[sel] = 1'b1;
  endtask

  task automatic send_word(input int sel, input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(sel, w[8*i +: 8], 1'b1);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    idle(3);
    n_checks++;
    if ({wv[0], bsy[0], fe[0], toe[0], ov[0]} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b, required 00000", {wv[0], bsy[0], fe[0], toe[0], ov[0]});
    end
    n_checks++;
    if (wd0 !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h, required 0", wd0); end
    n_checks++;
    if (wv !== 4'b0) begin n_fail++; $display("FAIL reset_valid_all: got %b, required 0000", wv); end
    reset_n = 1'b1;
    idle(3);
  endtask

  task automatic test_basic;
    rdy[0] = 1'b1;
    q0.push_back(32'h44332211);
    send_word(0, 32'h44332211);
    n_checks++;
    if (rise_cyc0 !== start_cyc + 155) begin
      n_fail++; $display("FAIL basic_latency: got cycle %0d, required %0d", rise_cyc0, start_cyc + 155);
    end
    idle(4);
    n_checks++;
    if (wv[0] !== 1'b0 || bsy[0] !== 1'b0) begin
      n_fail++; $display("FAIL basic_idle: got valid=%b busy=%b, required 0 0", wv[0], bsy[0]);
    end
    n_checks++;
    if (q0.size() != 0) begin n_fail++; $display("FAIL basic_delivered: got %0d pending, required 0", q0.size()); end
  endtask

  task automatic test_msb_first;
    rdy[1] = 1'b1;
    q1.push_back(32'h11223344);
    send_word(1, 32'h44332211);
    idle(4);
    n_checks++;
    if (q1.size() != 0) begin n_fail++; $display("FAIL msb_delivered: got %0d pending, required 0", q1.size()); end
  endtask

  task automatic test_two_byte;
    rdy[2] = 1'b1;
    q2.push_back(16'hCDAB);
    send_byte(2, 8'hAB, 1'b1);
    send_byte(2, 8'hCD, 1'b1);
    idle(4);
    n_checks++;
    if (q2.size() != 0) begin n_fail++; $display("FAIL b2_delivered: got %0d pending, required 0", q2.size()); end
  endtask

  task automatic test_frame_err;
    int fe0;
    fe0 = fe_cnt0;
    rdy[0] = 1'b1;
    send_byte(0, 8'h11, 1'b1);
    send_byte(0, 8'h22, 1'b0);
    idle(2 * CPB);
    n_checks++;
    if (fe_cnt0 !== fe0 + 1) begin n_fail++; $display("FAIL frame_err_pulse: got %0d, required %0d", fe_cnt0 - fe0, 1); end
    n_checks++;
    if (bsy[0] !== 1'b0) begin n_fail++; $display("FAIL frame_err_busy: got %b, required 0", bsy[0]); end
    q0.push_back(32'h04030201);
    send_word(0, 32'h04030201);
    idle(4);
    n_checks++;
    if (q0.size() != 0) begin n_fail++; $display("FAIL frame_err_word: got %0d pending, required 0", q0.size()); end
    n_checks++;
    if (fe_cnt0 !== fe0 + 1) begin n_fail++; $display("FAIL frame_err_extra: got %0d, required 1", fe_cnt0 - fe0); end
  endtask

  task automatic test_timeout;
    rdy[3] = 1'b1;
    send_byte(3, 8'h55, 1'b1);
    idle(380);
    n_checks++;
    if (to_cnt3 !== 0 || bsy[3] !== 1'b1) begin
      n_fail++; $display("FAIL timeout_early: got count=%0d busy=%b, required 0 1", to_cnt3, bsy[3]);
    end
    idle(40);
    n_checks++;
    if (to_cnt3 !== 1 || bsy[3] !== 1'b0) begin
      n_fail++; $display("FAIL timeout_fire: got count=%0d busy=%b, required 1 0", to_cnt3, bsy[3]);
    end
    q3.push_back(32'h44332211);
    send_word(3, 32'h44332211);
    idle(4);
    n_checks++;
    if (q3.size() != 0) begin n_fail++; $display("FAIL timeout_word: got %0d pending, required 0", q3.size()); end
  endtask

  task automatic test_overrun;
    int ov0;
    ov0 = ov_cnt0;
    rdy[0] = 1'b0;
    q0.push_back(32'hA4A3A2A1);
    send_word(0, 32'hA4A3A2A1);
    n_checks++;
    if (wv[0] !== 1'b1 || wd0 !== 32'hA4A3A2A1) begin
      n_fail++; $display("FAIL overrun_hold1: got valid=%b data=%h, required 1 a4a3a2a1", wv[0], wd0);
    end
    send_word(0, 32'hB4B3B2B1);
    n_checks++;
    if (ov_cnt0 !== ov0 + 1) begin n_fail++; $display("FAIL overrun_pulse: got %0d, required 1", ov_cnt0 - ov0); end
    n_checks++;
    if (wv[0] !== 1'b1 || wd0 !== 32'hA4A3A2A1) begin
      n_fail++; $display("FAIL overrun_hold2: got valid=%b data=%h, required 1 a4a3a2a1", wv[0], wd0);
    end
    rdy[0] = 1'b1;
    idle(4);
    n_checks++;
    if (wv[0] !== 1'b0 || q0.size() != 0) begin
      n_fail++; $display("FAIL overrun_drain: got valid=%b pending=%0d, required 0 0", wv[0], q0.size());
    end
  endtask

  task automatic test_glitch;
    int fe0, ov0;
    fe0 = fe_cnt0; ov0 = ov_cnt0;
    rx_v[0] = 1'b0;
    idle(3);
    rx_v[0] = 1'b1;
    idle(2 * CPB);
    n_checks++;
    if (bsy[0] !== 1'b0 || wv[0] !== 1'b0 || fe_cnt0 !== fe0 || ov_cnt0 !== ov0) begin
      n_fail++; $display("FAIL glitch_quiet: got busy=%b valid=%b fe=%0d ov=%0d, required 0 0 0 0",
                         bsy[0], wv[0], fe_cnt0 - fe0, ov_cnt0 - ov0);
    end
    q0.push_back(32'h0D0C0B0A);
    send_word(0, 32'h0D0C0B0A);
    idle(4);
    n_checks++;
    if (q0.size() != 0) begin n_fail++; $display("FAIL glitch_word: got %0d pending, required 0", q0.size()); end
  endtask

  task automatic test_reset_mid;
    rdy[0] = 1'b1;
    send_byte(0, 8'h99, 1'b1);
    rx_v[0] = 1'b0;
    idle(60);
    n_checks++;
    if (bsy[0] !== 1'b1) begin n_fail++; $display("FAIL reset_mid_busy: got %b, required 1", bsy[0]); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({wv[0], bsy[0], fe[0], toe[0], ov[0]} !== 5'b0 || wd0 !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid_async: got flags=%b data=%h, required 00000 0",
                         {wv[0], bsy[0], fe[0], toe[0], ov[0]}, wd0);
    end
    rx_v[0] = 1'b1;
    idle(3);
    reset_n = 1'b1;
    idle(3);
    q0.push_back(32'h78563412);
    send_word(0, 32'h78563412);
    idle(4);
    n_checks++;
    if (q0.size() != 0) begin n_fail++; $display("FAIL reset_mid_word: got %0d pending, required 0", q0.size()); end
  endtask

  initial begin
    reset_n = 1'b0;
    rx_v    = 4'b1111;
    rdy     = 4'b0000;
    test_reset;
    test_basic;
    test_msb_first;
    test_two_byte;
    test_frame_err;
    test_timeout;
    test_overrun;
    test_glitch;
    test_reset_mid;
    n_checks++;
    if (q0.size() + q1.size() + q2.size() + q3.size() != 0) begin
      n_fail++; $display("FAIL final_queues: got %0d pending, required 0", q0.size() + q1.size() + q2.size() + q3.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
